// File: rtl/spi_flash_read_seq.sv
// Serial-flash READ sequencer: sends opcode + 24-bit address through the SPI
// byte engine, then streams back the requested number of data bytes.
module spi_flash_read_seq #(
    parameter int unsigned LEN_W  = 8,
    parameter logic [7:0]  CMD_RD = 8'h03,
    parameter int unsigned TO_CYC = 64
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_start,
    input  logic [23:0]      I_addr,
    input  logic [LEN_W-1:0] I_len,
    input  logic             I_abort,
    output logic             O_busy,
    output logic             O_done,
    output logic             O_err,
    output logic [7:0]       O_rd_data,
    output logic             O_rd_valid,
    output logic             O_tx_en,
    output logic             O_rx_en,
    output logic [7:0]       O_tx_byte,
    input  logic             I_tx_done,
    input  logic             I_rx_done,
    input  logic [7:0]       I_rx_byte
);

    localparam int unsigned WD_W = $clog2(TO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_READ, S_FINISH} state_t;

    state_t           state_q, state_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             tx_en_q, tx_en_d;
    logic             rx_en_q, rx_en_d;
    logic [7:0]       tx_byte_q, tx_byte_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        wd_d        = wd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        tx_en_d     = tx_en_q;
        rx_en_d     = rx_en_q;
        tx_byte_d   = tx_byte_q;

        case (state_q)
            S_IDLE: begin
                // done_q high means FINISH/timeout just left; starts resume next cycle
                if (I_start && !done_q && (I_len != '0)) begin
                    addr_d     = I_addr;
                    len_d      = I_len;
                    tx_byte_d  = CMD_RD;
                    tx_en_d    = 1'b1;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    wd_d       = '0;
                    state_d    = S_CMD;
                end
            end
            S_CMD, S_READ: begin
                if (I_abort) begin
                    tx_en_d = 1'b0;
                    rx_en_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (I_tx_done || I_rx_done) begin
                    wd_d = '0;
                    if (state_q == S_CMD && I_tx_done) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: tx_byte_d = addr_q[23:16];
                            2'd1: tx_byte_d = addr_q[15:8];
                            2'd2: tx_byte_d = addr_q[7:0];
                            2'd3: begin
                                // swap enables on one edge so the engine keeps CS low
                                tx_en_d     = 1'b0;
                                rx_en_d     = 1'b1;
                                remaining_d = len_q;
                                state_d     = S_READ;
                            end
                        endcase
                    end
                    if (state_q == S_READ && I_rx_done) begin
                        rd_data_d   = I_rx_byte;
                        rd_valid_d  = 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == LEN_W'(1)) begin
                            rx_en_d = 1'b0;
                            state_d = S_FINISH;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    tx_en_d = 1'b0;
                    rx_en_d = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            tx_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign O_busy     = busy_q;
    assign O_done     = done_q;
    assign O_err      = err_q;
    assign O_rd_data  = rd_data_q;
    assign O_rd_valid = rd_valid_q;
    assign O_tx_en    = tx_en_q;
    assign O_rx_en    = rx_en_q;
    assign O_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: a behavioural SPI byte engine plus a
// transaction scoreboard checked every cycle, and directed scenarios.
module tb_spi_flash_read_seq;

    localparam int unsigned BYTE_CYC = 8;

    logic        I_clk, I_rst, I_start, I_abort;
    logic [23:0] I_addr;
    logic [7:0]  I_len;
    logic        O_busy, O_done, O_err, O_rd_valid, O_tx_en, O_rx_en;
    logic [7:0]  O_rd_data, O_tx_byte;
    logic        I_tx_done, I_rx_done;
    logic [7:0]  I_rx_byte;

    spi_flash_read_seq #(.LEN_W(8), .CMD_RD(8'h03), .TO_CYC(64)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_addr(I_addr),
        .I_len(I_len), .I_abort(I_abort), .O_busy(O_busy), .O_done(O_done),
        .O_err(O_err), .O_rd_data(O_rd_data), .O_rd_valid(O_rd_valid),
        .O_tx_en(O_tx_en), .O_rx_en(O_rx_en), .O_tx_byte(O_tx_byte),
        .I_tx_done(I_tx_done), .I_rx_done(I_rx_done), .I_rx_byte(I_rx_byte)
    );

    int          checks, failures;
    int          cyc, n_done, n_err, n_rd, tx_rises, done_cyc, last_pulse_cyc;
    logic        handoff, exp_err, withhold_rx;
    logic [7:0]  got_tx[$], exp_tx[$], exp_rd[$], rx_src[$], tx_log[$], rd_log[$];

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge I_clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Engine model: a byte takes BYTE_CYC cycles; tx byte sampled at byte start.
    initial begin : engine
        int unsigned cnt;
        logic [7:0]  b;
        cnt = 0;
        forever begin
            @(negedge I_clk);
            I_tx_done = 1'b0;
            I_rx_done = 1'b0;
            if (!O_tx_en && !O_rx_en) begin
                cnt = 0;
            end else if (O_tx_en) begin
                if (cnt == 0) got_tx.push_back(O_tx_byte);
                cnt++;
                if (cnt == BYTE_CYC) begin
                    cnt = 0;
                    I_tx_done = 1'b1;
                    last_pulse_cyc = cyc + 1;
                end
            end else if (!withhold_rx) begin
                cnt++;
                if (cnt == BYTE_CYC) begin
                    cnt = 0;
                    b = (rx_src.size() > 0) ? rx_src.pop_front() : 8'hEE;
                    I_rx_byte = b;
                    I_rx_done = 1'b1;
                    exp_rd.push_back(b);
                    last_pulse_cyc = cyc + 1;
                end
            end
        end
    end

    // Scoreboard compare, once per cycle after the outputs settle.
    initial begin : compare
        logic       prev_tx;
        logic [7:0] b;
        prev_tx = 1'b0;
        forever begin
            @(posedge I_clk);
            #2;
            if (O_tx_en || O_rx_en) chk("en_exclusive", 32'(O_tx_en & O_rx_en), 0);
            if (O_tx_en && !prev_tx) tx_rises++;
            if (!O_tx_en && prev_tx) handoff = O_rx_en;
            prev_tx = O_tx_en;
            while (got_tx.size() > 0) begin
                b = got_tx.pop_front();
                tx_log.push_back(b);
                chk("tx_expected_pending", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            end
            if (O_rd_valid) begin
                n_rd++;
                rd_log.push_back(O_rd_data);
                chk("rd_expected_pending", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) chk("rd_data", 32'(O_rd_data), 32'(exp_rd.pop_front()));
            end
            if (O_err) chk("err_with_done", 32'(O_done), 1);
            if (O_done) begin
                n_done++;
                done_cyc = cyc;
                if (O_err) n_err++;
                chk("done_err", 32'(O_err), 32'(exp_err));
                chk("done_busy_low", 32'(O_busy), 0);
                chk("done_rd_drained", 32'(exp_rd.size()), 0);
            end
        end
    end

    task automatic tick();
        @(posedge I_clk);
        #3;
    endtask

    task automatic do_start(input logic [23:0] a, input logic [7:0] l, input logic expect_txn);
        @(negedge I_clk);
        I_start = 1'b1;
        I_addr  = a;
        I_len   = l;
        if (expect_txn && l != 0) begin
            exp_tx.push_back(8'h03);
            exp_tx.push_back(a[23:16]);
            exp_tx.push_back(a[15:8]);
            exp_tx.push_back(a[7:0]);
        end
        @(negedge I_clk);
        I_start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned max, input string nm);
        int          n0;
        int unsigned k;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < max) begin
            tick();
            k++;
        end
        chk(nm, 32'(n_done - n0), 1);
    endtask

    task automatic new_txn();
        tx_log.delete();
        rd_log.delete();
        tx_rises = 0;
        handoff  = 1'b0;
    endtask

    initial begin : main
        int          d0, r0, e0;
        int unsigned k;
        logic        any_high;
        checks = 0; failures = 0; n_done = 0; n_err = 0; n_rd = 0;
        tx_rises = 0; done_cyc = 0; last_pulse_cyc = 0;
        handoff = 1'b0; exp_err = 1'b0; withhold_rx = 1'b0;
        I_rst = 1'b1; I_start = 1'b0; I_abort = 1'b0; I_addr = '0; I_len = '0;
        I_tx_done = 1'b0; I_rx_done = 1'b0; I_rx_byte = '0;

        repeat (3) tick();
        @(negedge I_clk);
        I_rst = 1'b0;
        tick();
        chk("rst_busy", 32'(O_busy), 0);
        chk("rst_done", 32'(O_done), 0);
        chk("rst_tx_en", 32'(O_tx_en), 0);
        chk("rst_rx_en", 32'(O_rx_en), 0);
        chk("rst_tx_byte", 32'(O_tx_byte), 0);
        chk("rst_rd_data", 32'(O_rd_data), 0);

        // 1: basic read of two bytes
        new_txn();
        rx_src.push_back(8'hA5);
        rx_src.push_back(8'h3C);
        d0 = n_done; r0 = n_rd;
        do_start(24'h123456, 8'd2, 1'b1);
        chk("t1_busy", 32'(O_busy), 1);
        wait_done(400, "t1_done_seen");
        chk("t1_tx_count", 32'(tx_log.size()), 4);
        if (tx_log.size() == 4) begin
            chk("t1_tx0", 32'(tx_log[0]), 32'h03);
            chk("t1_tx1", 32'(tx_log[1]), 32'h12);
            chk("t1_tx2", 32'(tx_log[2]), 32'h34);
            chk("t1_tx3", 32'(tx_log[3]), 32'h56);
        end
        chk("t1_rd_count", 32'(n_rd - r0), 2);
        if (rd_log.size() == 2) begin
            chk("t1_rd0", 32'(rd_log[0]), 32'hA5);
            chk("t1_rd1", 32'(rd_log[1]), 32'h3C);
        end
        chk("t1_tx_en_rises", 32'(tx_rises), 1);
        chk("t1_handoff", 32'(handoff), 1);
        chk("t1_err", 32'(n_err), 0);
        tick();
        chk("t1_done_one_cycle", 32'(O_done), 0);
        chk("t1_cs_high", 32'(O_tx_en | O_rx_en | O_busy), 0);

        // 2: zero-length request is ignored
        d0 = n_done;
        do_start(24'hABCDEF, 8'd0, 1'b1);
        any_high = 1'b0;
        repeat (100) begin
            tick();
            any_high = any_high | O_busy | O_tx_en | O_rx_en | O_done;
        end
        chk("t2_len0_quiet", 32'(any_high), 0);
        chk("t2_no_done", 32'(n_done - d0), 0);

        // 3: start while busy ignored; start right after done accepted
        new_txn();
        r0 = n_rd;
        rx_src.push_back(8'h77);
        do_start(24'hABCDEF, 8'd1, 1'b1);
        repeat (10) tick();
        do_start(24'h111111, 8'd3, 1'b0);
        wait_done(400, "t3_done_seen");
        chk("t3_tx_count", 32'(tx_log.size()), 4);
        chk("t3_rd_count", 32'(n_rd - r0), 1);
        new_txn();
        r0 = n_rd;
        rx_src.push_back(8'h81);
        tick();
        do_start(24'h00FF10, 8'd1, 1'b1);
        chk("t3_back_to_back_busy", 32'(O_busy), 1);
        wait_done(400, "t3b_done_seen");
        chk("t3b_tx_count", 32'(tx_log.size()), 4);
        if (rd_log.size() == 1) chk("t3b_rd0", 32'(rd_log[0]), 32'h81);

        // 4: abort the cycle after the second tx_done
        new_txn();
        tick();
        d0 = n_done; r0 = n_rd; e0 = n_err;
        do_start(24'hC0FFEE, 8'd2, 1'b1);
        k = 0;
        while (k < 200 && tx_rises == 1 && !(I_tx_done && tx_log.size() == 2)) begin
            tick();
            k++;
        end
        chk("t4_second_tx_done_seen", 32'(I_tx_done), 1);
        @(negedge I_clk);
        I_abort = 1'b1;
        tick();
        I_abort = 1'b0;
        chk("t4_abort_quiet", 32'(O_tx_en | O_rx_en | O_busy), 0);
        repeat (100) tick();
        chk("t4_no_done", 32'(n_done - d0), 0);
        chk("t4_no_err", 32'(n_err - e0), 0);
        chk("t4_no_rd", 32'(n_rd - r0), 0);
        chk("t4_tx_count", 32'(tx_log.size()), 3);
        exp_tx.delete();

        // 5: watchdog while rx_done is withheld
        new_txn();
        withhold_rx = 1'b1;
        exp_err = 1'b1;
        e0 = n_err;
        do_start(24'h0ABCDE, 8'd2, 1'b1);
        wait_done(400, "t5_done_seen");
        chk("t5_err_pulse", 32'(n_err - e0), 1);
        chk("t5_timeout_gap", 32'(done_cyc - last_pulse_cyc), 64);
        chk("t5_enables_off", 32'(O_tx_en | O_rx_en), 0);
        tick();
        chk("t5_err_one_cycle", 32'(O_err | O_done), 0);
        withhold_rx = 1'b0;
        exp_err = 1'b0;

        // 6: reset mid-READ, then a one-byte read from address 0
        new_txn();
        tick();
        r0 = n_rd;
        rx_src.push_back(8'h11);
        rx_src.push_back(8'h22);
        rx_src.push_back(8'h33);
        do_start(24'h445566, 8'd3, 1'b1);
        k = 0;
        while (n_rd == r0 && k < 300) begin
            tick();
            k++;
        end
        chk("t6_in_read", 32'(n_rd - r0), 1);
        @(negedge I_clk);
        I_rst = 1'b1;
        tick();
        chk("t6_rst_outputs", 32'({O_busy, O_done, O_err, O_rd_valid, O_tx_en, O_rx_en}), 0);
        chk("t6_rst_rd_data", 32'(O_rd_data), 0);
        chk("t6_rst_tx_byte", 32'(O_tx_byte), 0);
        @(negedge I_clk);
        I_rst = 1'b0;
        tick();
        exp_tx.delete();
        exp_rd.delete();
        rx_src.delete();
        new_txn();
        r0 = n_rd;
        rx_src.push_back(8'h5A);
        do_start(24'h000000, 8'd1, 1'b1);
        wait_done(400, "t6_done_seen");
        chk("t6_tx_count", 32'(tx_log.size()), 4);
        if (tx_log.size() == 4) chk("t6_tx_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h03000000);
        chk("t6_rd_count", 32'(n_rd - r0), 1);
        if (rd_log.size() == 1) chk("t6_rd0", 32'(rd_log[0]), 32'h5A);

        // 7: maximum burst length
        new_txn();
        tick();
        r0 = n_rd;
        for (int i = 0; i < 255; i++) rx_src.push_back(8'(i));
        do_start(24'hFEDCBA, 8'd255, 1'b1);
        wait_done(4000, "t7_done_seen");
        chk("t7_rd_count", 32'(n_rd - r0), 255);
        if (rd_log.size() == 255) chk("t7_rd_last", 32'(rd_log[254]), 32'hFE);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
